// File: rtl/pattern_pkg.sv
// Shared constants and types for the RGB stripe pattern checker.
// Phase, colour and FSM encodings match the transmit-side generator.
package pattern_pkg;

  localparam int C_CNT_W_DEFAULT = 16;

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  localparam logic [7:0] C_ON  = 8'hFF;
  localparam logic [7:0] C_OFF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic pixel_t expected_pixel(input logic [1:0] ph);
    pixel_t p;
    case (ph)
      PH_G:    p = '{r: C_OFF, g: C_ON,  b: C_OFF};
      PH_B:    p = '{r: C_OFF, g: C_OFF, b: C_ON};
      default: p = '{r: C_ON,  g: C_OFF, b: C_OFF};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// One-stage history register per timing signal; rise/fall are
// combinational pulses against the previous sample.
module sync_edge_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sig,
  output logic [2:0] rise,
  output logic [2:0] fall
);

  logic [2:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 3'b000;
    end else begin
      prev <= sig;
    end
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/pattern_checker.sv
// Receive-side checker for the R->G->B stripe pattern across replicated
// lanes; lane 0 provides timing and is the reference for the other lanes.
module pattern_checker
  import pattern_pkg::*;
#(
  parameter int C_PORT_NUM = 4,
  parameter int C_CNT_W    = C_CNT_W_DEFAULT
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic                    ENABLE_I,
  input  logic                    CLR_I,
  input  logic [C_PORT_NUM-1:0]   VS_I,
  input  logic [C_PORT_NUM-1:0]   HS_I,
  input  logic [C_PORT_NUM-1:0]   DE_I,
  input  logic [C_PORT_NUM*8-1:0] R_I,
  input  logic [C_PORT_NUM*8-1:0] G_I,
  input  logic [C_PORT_NUM*8-1:0] B_I,
  output logic                    LOCK_O,
  output logic                    ERR_O,
  output logic [31:0]             ERR_CNT_O,
  output logic [C_CNT_W-1:0]      FIRST_ERR_X_O,
  output logic [C_CNT_W-1:0]      FIRST_ERR_Y_O,
  output logic                    FRAME_DONE_O,
  output logic                    FRAME_ERR_O,
  output logic [C_CNT_W-1:0]      FRAME_CNT_O,
  output logic [C_CNT_W-1:0]      PIX_PER_LINE_O,
  output logic [C_CNT_W-1:0]      LINES_O
);

  logic vs0, hs0, de0;
  logic [2:0] rise, fall;
  logic vs_rise, vs_fall, de_rise, de_fall;
  logic unused_hs_edges;
  logic [1:0] ph, exp_ph;
  pixel_t lane0_pix, exp_pix;
  logic lane_mismatch, pix_err;
  logic [C_CNT_W-1:0] x_cnt, y_cnt, pos_x;
  state_t state;
  logic frame_err_acc;
  logic [31:0] err_cnt;
  logic first_seen;

  assign vs0 = VS_I[0];
  assign hs0 = HS_I[0];
  assign de0 = DE_I[0];

  sync_edge_det u_edge (
    .clk   (CLK_I),
    .rst_n (RSTN_I),
    .sig   ({vs0, hs0, de0}),
    .rise  (rise),
    .fall  (fall)
  );

  assign vs_rise = rise[2];
  assign vs_fall = fall[2];
  assign de_rise = rise[0];
  assign de_fall = fall[0];
  assign unused_hs_edges = &{1'b0, rise[1], fall[1]};

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      ph <= PH_R;
    end else if (vs0 || hs0) begin
      ph <= PH_R;
    end else if (de0) begin
      ph <= (ph == PH_B) ? PH_R : ph + 2'd1;
    end
  end

  // A pixel that shares its cycle with a sync pulse belongs to phase 0.
  assign exp_ph    = (vs0 || hs0) ? PH_R : ph;
  assign exp_pix   = expected_pixel(exp_ph);
  assign lane0_pix = '{r: R_I[7:0], g: G_I[7:0], b: B_I[7:0]};

  always_comb begin
    lane_mismatch = 1'b0;
    for (int k = 1; k < C_PORT_NUM; k++) begin
      if ({VS_I[k], HS_I[k], DE_I[k], R_I[8*k +: 8], G_I[8*k +: 8], B_I[8*k +: 8]} !=
          {vs0, hs0, de0, R_I[7:0], G_I[7:0], B_I[7:0]}) begin
        lane_mismatch = 1'b1;
      end
    end
  end

  assign pix_err = (state == CHECK) && de0 && ((lane0_pix != exp_pix) || lane_mismatch);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (de_rise) begin
        x_cnt <= C_CNT_W'(1);
      end else if (de0) begin
        x_cnt <= x_cnt + C_CNT_W'(1);
      end
      if (vs_fall) begin
        y_cnt <= '0;
      end else if (de_fall) begin
        y_cnt <= y_cnt + C_CNT_W'(1);
      end
    end
  end

  assign pos_x = de_rise ? '0 : x_cnt;

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state          <= IDLE;
      LOCK_O         <= 1'b0;
      FRAME_DONE_O   <= 1'b0;
      FRAME_ERR_O    <= 1'b0;
      FRAME_CNT_O    <= '0;
      PIX_PER_LINE_O <= '0;
      LINES_O        <= '0;
      frame_err_acc  <= 1'b0;
    end else begin
      FRAME_DONE_O <= 1'b0;
      if (pix_err) begin
        frame_err_acc <= 1'b1;
      end
      if (!ENABLE_I) begin
        state  <= IDLE;
        LOCK_O <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= WAIT;
            LOCK_O <= 1'b0;
          end
          // Only a full frame is checked, so lock waits for a VS falling edge.
          WAIT: begin
            if (vs_fall) begin
              state         <= CHECK;
              LOCK_O        <= 1'b1;
              frame_err_acc <= 1'b0;
            end
          end
          CHECK: begin
            if (de_fall) begin
              PIX_PER_LINE_O <= x_cnt;
            end
            if (vs_rise) begin
              FRAME_DONE_O  <= 1'b1;
              FRAME_ERR_O   <= frame_err_acc || pix_err;
              frame_err_acc <= 1'b0;
              FRAME_CNT_O   <= FRAME_CNT_O + C_CNT_W'(1);
              LINES_O       <= y_cnt;
            end
          end
          default: begin
            state  <= IDLE;
            LOCK_O <= 1'b0;
          end
        endcase
      end
      if (CLR_I) begin
        FRAME_CNT_O <= '0;
      end
    end
  end

  // Clear takes priority, so an error arriving with CLR_I is dropped.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      ERR_O         <= 1'b0;
      err_cnt       <= '0;
      FIRST_ERR_X_O <= '0;
      FIRST_ERR_Y_O <= '0;
      first_seen    <= 1'b0;
    end else if (CLR_I) begin
      ERR_O         <= 1'b0;
      err_cnt       <= '0;
      FIRST_ERR_X_O <= '0;
      FIRST_ERR_Y_O <= '0;
      first_seen    <= 1'b0;
    end else if (pix_err) begin
      ERR_O <= 1'b1;
      if (err_cnt != 32'hFFFF_FFFF) begin
        err_cnt <= err_cnt + 32'd1;
      end
      if (!first_seen) begin
        FIRST_ERR_X_O <= pos_x;
        FIRST_ERR_Y_O <= y_cnt;
        first_seen    <= 1'b1;
      end
    end
  end

  assign ERR_CNT_O = err_cnt;

endmodule

// File: doc/pattern_checker.md
# pattern_checker

Receive-side counterpart of the RGB stripe pattern generator. Consumes a multi-lane video stream (VS/HS/DE + 8-bit R/G/B per lane) at the frame-buffer output or loopback point. Checks every active pixel against the R→G→B cycling pattern, where each line restarts at R, and checks that all lanes carry identical data. Reports error counts, first-error position, measured frame geometry and per-frame pass/fail.

## Interface
Parameters:
- C_PORT_NUM, 4, number of replicated lanes; lane 0 is the reference lane
- C_CNT_W, 16, width of geometry, position and frame counters

Ports (one clock; reset is asynchronous and active-low):
- CLK_I  in  1  pixel clock
- RSTN_I  in  1  asynchronous active-low reset
- ENABLE_I  in  1  checker enable; low forces IDLE
- CLR_I  in  1  synchronous clear of ERR_O, ERR_CNT_O, FIRST_ERR_*, FRAME_CNT_O
- VS_I, HS_I, DE_I  in  C_PORT_NUM each  sync/enable per lane; only bit 0 is used for timing
- R_I, G_I, B_I  in  C_PORT_NUM*8 each  pixel data; lane k occupies bits [8k+7:8k]
- LOCK_O  out  1  high in CHECK state
- ERR_O  out  1  sticky: any error since reset/CLR_I
- ERR_CNT_O  out  32  saturating count of erroneous pixels
- FIRST_ERR_X_O, FIRST_ERR_Y_O  out  C_CNT_W  pixel/line index of first error
- FRAME_DONE_O  out  1  one-cycle pulse at end of each checked frame
- FRAME_ERR_O  out  1  valid with FRAME_DONE_O; high if that frame had ≥1 error
- FRAME_CNT_O  out  C_CNT_W  checked frames, wraps
- PIX_PER_LINE_O, LINES_O  out  C_CNT_W  geometry of last completed line/frame

## Operation
- Expected phase register `ph` (0..2) uses the generator semantics. It clears when VS_I[0] or HS_I[0] is high. Otherwise it advances on DE_I[0] and wraps 2→0. Clear has priority over advance.
- Expected pixel for phase 0/1/2: (255,0,0) / (0,255,0) / (0,0,255).
- Pixel error, evaluated on a DE_I[0] cycle in CHECK: lane 0 ≠ expected, or any lane k ≠ lane 0 (R, G, B, VS, HS or DE). At most one error per pixel.
- FSM:
  - IDLE: entered on reset or ENABLE_I low. Goes to WAIT when ENABLE_I is high.
  - WAIT: waits for VS_I[0] falling edge, then goes to CHECK. Partial frames are never checked.
  - CHECK: on each VS_I[0] rising edge, emits FRAME_DONE_O and stays in CHECK. ENABLE_I low returns to IDLE from any state.
- x counter counts DE pixels in the current line. It resets on DE rising edge.
- y counter counts DE falling edges in the current frame. It resets on VS falling edge.
- On each DE falling edge, PIX_PER_LINE_O ← x.
- On each VS rising edge, LINES_O ← y.
- The first error after reset or CLR_I latches x/y into FIRST_ERR_*. Later errors do not overwrite it.
- ERR_CNT_O saturates at 0xFFFF_FFFF. FRAME_CNT_O wraps at 2^C_CNT_W.
- Simultaneous CLR_I and error: clear wins; the error in that cycle is not counted.
- Reset values: all outputs 0; FSM in IDLE; `ph` = 0.

## Timing
- All outputs are registered.
- ERR_CNT_O/ERR_O reflect a pixel error 1 cycle after the offending DE cycle.
- FRAME_DONE_O goes high the cycle after the VS rising edge (detected as VS_I[0]=1 with previous sample 0), for exactly 1 cycle. FRAME_ERR_O, LINES_O and the FRAME_CNT_O increment update on the same edge.
- LOCK_O rises 1 cycle after the VS falling edge in WAIT.
- The first frame after entering CHECK produces FRAME_DONE_O at its closing VS.
- Asynchronous reset mid-frame: outputs clear immediately. Checking resumes only after the next full VS falling edge.
- DE with HS/VS high in the same cycle: the pixel is checked against phase 0.

## Structure
- Package `pattern_pkg`:
  - phase constants PH_R/PH_G/PH_B
  - colour constants C_ON=8'hFF, C_OFF=8'h00
  - FSM state encoding (IDLE, WAIT, CHECK)
  - default C_CNT_W
- Sub-module `sync_edge_det`: one-stage register per signal (VS, HS, DE) producing rise/fall pulses. Instantiated once on lane 0.

## Test plan
- 8×4 active frame, clean pattern, 2 frames → LOCK_O=1, ERR_CNT_O=0, FRAME_DONE_O ×2 with FRAME_ERR_O=0, PIX_PER_LINE_O=8, LINES_O=4, FRAME_CNT_O=2.
- Corrupt pixel x=5, y=2 of lane 0 (G=0x80) → ERR_CNT_O=1 one cycle later, FIRST_ERR_X_O=5, FIRST_ERR_Y_O=2, FRAME_ERR_O=1 for that frame only.
- Lane 3 B differs from lane 0 on every pixel of one 8-pixel line → ERR_CNT_O=8, lane 0 pattern otherwise correct.
- Enable mid-frame: errors injected before the first VS fall → ERR_CNT_O=0, LOCK_O rises only after that VS fall.
- Preload ERR_CNT_O near saturation (force 0xFFFF_FFFE), inject 3 errors → 0xFFFF_FFFF. Then CLR_I pulse coincident with an error → all error outputs 0.
- RSTN_I low for 1 cycle mid-line → all outputs 0 asynchronously, FSM IDLE, no FRAME_DONE_O for the interrupted frame.
